// File: rtl/sprite_addr_gen.sv
// Scrolling sprite ROM address generator: maps the VGA scan position onto a
// tiled (or single-copy clipped) sprite with per-frame horizontal/vertical scroll.
module sprite_addr_gen #(
  parameter int IMG_W  = 200,
  parameter int IMG_H  = 90,
  parameter int H_OFF  = 180,
  parameter int V_OFF  = 25,
  parameter int STEP   = 4,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic [9:0]        h_cnt,
  input  logic [9:0]        v_cnt,
  input  logic              frame_start,
  input  logic [1:0]        scroll_en,
  input  logic              clip_mode,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              in_range
);

  localparam int PW = (ADDR_W > 21) ? ADDR_W : 21;
  localparam logic [10:0] W_S   = 11'(IMG_W);
  localparam logic [10:0] H_S   = 11'(IMG_H);
  localparam logic [9:0]  W_M1  = 10'(IMG_W - 1);
  localparam logic [9:0]  H_M1  = 10'(IMG_H - 1);
  localparam logic [10:0] HO_S  = 11'(H_OFF);
  localparam logic [10:0] VO_S  = 11'(V_OFF);
  localparam logic [10:0] STP_S = 11'(STEP);
  localparam logic [PW-1:0] W_P = PW'(IMG_W);

  logic [9:0]        scroll_x_q, scroll_x_d, scroll_y_q, scroll_y_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic              xw_q, xw_d, yw_q, yw_d;
  logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
  logic              in_range_q, in_range_d;

  logic [10:0]   x_sum, y_sum, sx_sum, sy_sum;
  logic [9:0]    x_base, y_base;
  logic [PW-1:0] prod;

  // Offsets and scroll are both below the image size, so one conditional
  // subtract is enough to bring each sum back into range.
  always_comb begin
    x_sum  = HO_S + {1'b0, scroll_x_q};
    y_sum  = VO_S + {1'b0, scroll_y_q};
    x_base = (x_sum >= W_S) ? 10'(x_sum - W_S) : x_sum[9:0];
    y_base = (y_sum >= H_S) ? 10'(y_sum - H_S) : y_sum[9:0];
    sx_sum = {1'b0, scroll_x_q} + STP_S;
    sy_sum = {1'b0, scroll_y_q} + STP_S;
  end

  always_comb begin
    scroll_x_d = scroll_x_q;
    scroll_y_d = scroll_y_q;
    if (frame_start && scroll_en[0])
      scroll_x_d = (sx_sum >= W_S) ? 10'(sx_sum - W_S) : sx_sum[9:0];
    if (frame_start && scroll_en[1])
      scroll_y_d = (sy_sum >= H_S) ? 10'(sy_sum - H_S) : sy_sum[9:0];
  end

  // x steps on every pixel and reloads per line; y only moves at line starts.
  always_comb begin
    x_d  = x_q;
    xw_d = xw_q;
    y_d  = y_q;
    yw_d = yw_q;
    if (pix_en) begin
      if (h_cnt == 10'd0) begin
        x_d  = x_base;
        xw_d = 1'b0;
        if (v_cnt == 10'd0) begin
          y_d  = y_base;
          yw_d = 1'b0;
        end else if (y_q == H_M1) begin
          y_d  = 10'd0;
          yw_d = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else if (x_q == W_M1) begin
        x_d  = 10'd0;
        xw_d = 1'b1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  always_comb begin
    prod         = PW'(y_d) * W_P + PW'(x_d);
    pixel_addr_d = pixel_addr_q;
    in_range_d   = in_range_q;
    if (pix_en) begin
      pixel_addr_d = ADDR_W'(prod);
      in_range_d   = clip_mode ? !(xw_d | yw_d) : 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scroll_x_q   <= '0;
      scroll_y_q   <= '0;
      x_q          <= '0;
      y_q          <= '0;
      xw_q         <= 1'b0;
      yw_q         <= 1'b0;
      pixel_addr_q <= '0;
      in_range_q   <= 1'b0;
    end else begin
      scroll_x_q   <= scroll_x_d;
      scroll_y_q   <= scroll_y_d;
      x_q          <= x_d;
      y_q          <= y_d;
      xw_q         <= xw_d;
      yw_q         <= yw_d;
      pixel_addr_q <= pixel_addr_d;
      in_range_q   <= in_range_d;
    end
  end

  assign pixel_addr = pixel_addr_q;
  assign in_range   = in_range_q;

endmodule

// File: tb/tb_sprite_addr_gen.sv
// Bench for sprite_addr_gen: directed scenarios plus randomized frames checked
// against a modulo-arithmetic model of the scan-to-sprite mapping.
module tb_sprite_addr_gen;

  localparam int IMG_W  = 200;
  localparam int IMG_H  = 90;
  localparam int H_OFF  = 180;
  localparam int V_OFF  = 25;
  localparam int STEP   = 4;
  localparam int ADDR_W = 17;
  localparam int W      = ADDR_W + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pix_en = 1'b0;
  logic [9:0]        h_cnt = '0;
  logic [9:0]        v_cnt = '0;
  logic              frame_start = 1'b0;
  logic [1:0]        scroll_en = 2'b00;
  logic              clip_mode = 1'b0;
  logic [ADDR_W-1:0] pixel_addr;
  logic              in_range;

  sprite_addr_gen #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .H_OFF(H_OFF), .V_OFF(V_OFF),
    .STEP(STEP), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .frame_start(frame_start), .scroll_en(scroll_en), .clip_mode(clip_mode),
    .pixel_addr(pixel_addr), .in_range(in_range)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard: {in_range, pixel_addr} expected after each edge
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp = '0;
  int sx = 0, sy = 0, xb = 0, yb = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus; the model maps scan position to sprite pixel with
  // plain modulo arithmetic from the line/frame base positions.
  task automatic drive(input logic pe, input int h, input int v, input logic fs, input logic clip);
    logic [W-1:0] e;
    int xs, ys;
    @(negedge clk);
    pix_en = pe; h_cnt = 10'(h); v_cnt = 10'(v); frame_start = fs; clip_mode = clip;
    if (pe) begin
      if (h == 0) begin
        xb = (H_OFF + sx) % IMG_W;
        if (v == 0) yb = (V_OFF + sy) % IMG_H;
      end
      xs = xb + h;
      ys = yb + v;
      e[ADDR_W-1:0] = ADDR_W'((ys % IMG_H) * IMG_W + (xs % IMG_W));
      e[ADDR_W]     = clip ? !(xs >= IMG_W || ys >= IMG_H) : 1'b1;
      last_exp = e;
    end
    exp_q.push_back(last_exp);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("pixel_addr", 32'(pixel_addr), 32'(e[ADDR_W-1:0]));
    check_eq("in_range", 32'(in_range), 32'(e[ADDR_W]));
    if (fs) begin
      if (scroll_en[0]) sx = (sx + STEP) % IMG_W;
      if (scroll_en[1]) sy = (sy + STEP) % IMG_H;
    end
    pix_en = 1'b0;
    frame_start = 1'b0;
  endtask

  initial begin
    int nv, len;
    logic coin;

    repeat (3) @(negedge clk);
    check_eq("reset_addr", 32'(pixel_addr), 32'd0);
    check_eq("reset_in_range", 32'(in_range), 32'd0);
    rst_n = 1'b1;

    // line 0 with x wrap, clip mode
    for (int h = 0; h < 230; h++) begin
      drive(1'b1, h, 0, 1'b0, 1'b1);
      if (h == 0) begin
        check_eq("dflt_h0_addr", 32'(pixel_addr), 32'd5180);
        check_eq("dflt_h0_inr", 32'(in_range), 32'd1);
      end
      if (h == 19) check_eq("dflt_h19_addr", 32'(pixel_addr), 32'd5199);
      if (h == 20) begin
        check_eq("xwrap_addr", 32'(pixel_addr), 32'd5000);
        check_eq("xwrap_inr", 32'(in_range), 32'd0);
      end
    end
    drive(1'b1, 0, 1, 1'b0, 1'b1);
    check_eq("line1_addr", 32'(pixel_addr), 32'd5380);
    check_eq("line1_inr", 32'(in_range), 32'd1);
    for (int h = 1; h < 3; h++) drive(1'b1, h, 1, 1'b0, 1'b1);

    // lines down to past the y wrap
    for (int v = 2; v <= 70; v++) begin
      for (int h = 0; h < 3; h++) begin
        drive(1'b1, h, v, 1'b0, 1'b1);
        if (v == 65 && h == 0) check_eq("ywrap_addr", 32'(pixel_addr), 32'd180);
        if (v >= 65) check_eq("ywrap_inr", 32'(in_range), 32'd0);
      end
    end

    // horizontal scroll
    scroll_en = 2'b01;
    drive(1'b0, 2, 70, 1'b1, 1'b0);
    drive(1'b1, 0, 0, 1'b0, 1'b0);
    check_eq("scroll1_addr", 32'(pixel_addr), 32'd5184);
    for (int i = 0; i < 4; i++) drive(1'b0, 0, 0, 1'b1, 1'b0);
    drive(1'b1, 0, 0, 1'b0, 1'b0);
    check_eq("scroll5_addr", 32'(pixel_addr), 32'd5000);

    // asynchronous reset between clock edges
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_addr", 32'(pixel_addr), 32'd0);
    check_eq("async_rst_inr", 32'(in_range), 32'd0);
    sx = 0; sy = 0; last_exp = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // frame_start coinciding with the frame load
    drive(1'b1, 0, 0, 1'b1, 1'b0);
    check_eq("coin_frame0", 32'(pixel_addr), 32'd5180);
    drive(1'b1, 1, 0, 1'b0, 1'b0);
    drive(1'b1, 0, 0, 1'b0, 1'b0);
    check_eq("coin_frame1", 32'(pixel_addr), 32'd5184);

    // randomized frames: random line lengths, idle cycles, clip and scroll
    for (int f = 0; f < 6; f++) begin
      scroll_en = 2'($urandom_range(0, 3));
      nv = $urandom_range(60, 100);
      coin = 1'($urandom_range(0, 1));
      if (!coin) drive(1'b0, 0, 0, 1'b1, 1'($urandom_range(0, 1)));
      for (int v = 0; v < nv; v++) begin
        len = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 240) : $urandom_range(1, 30);
        for (int h = 0; h < len; h++) begin
          if ($urandom_range(0, 3) == 0) drive(1'b0, h, v, 1'b0, 1'($urandom_range(0, 1)));
          drive(1'b1, h, v, coin && v == 0 && h == 0, 1'($urandom_range(0, 1)));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_addr_gen.md
SPRITE_ADDR_GEN -- requirements
Module: sprite_addr_gen

Interface
REQ-001 SHALL have parameter IMG_W, default 200, sprite width in pixels (2..1023).
REQ-002 SHALL have parameter IMG_H, default 90, sprite height in lines (2..1023).
REQ-003 SHALL have parameter H_OFF, default 180, horizontal start offset; legal range 0..IMG_W-1.
REQ-004 SHALL have parameter V_OFF, default 25, vertical start offset; legal range 0..IMG_H-1.
REQ-005 SHALL have parameter STEP, default 4, scroll increment per frame; legal range 0..min(IMG_W,IMG_H)-1.
REQ-006 SHALL have parameter ADDR_W, default 17, pixel_addr width; IMG_W*IMG_H SHALL fit in ADDR_W bits.
REQ-007 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port pix_en, input, 1, pixel strobe; state advances only when high.
REQ-010 SHALL have port h_cnt, input, 10, VGA horizontal count; increments by 1 per pix_en and returns to 0 each line.
REQ-011 SHALL have port v_cnt, input, 10, VGA vertical count; constant within a line.
REQ-012 SHALL have port frame_start, input, 1, single-cycle pulse once per frame.
REQ-013 SHALL have port scroll_en, input, 2, bit0 enables horizontal scroll and bit1 enables vertical scroll.
REQ-014 SHALL have port clip_mode, input, 1, 0 = tile (wrap) and 1 = single copy (clip).
REQ-015 SHALL have port pixel_addr, output, ADDR_W, registered ROM address y*IMG_W+x.
REQ-016 SHALL have port in_range, output, 1, registered flag; 1 when pixel_addr is inside the displayed copy.

Function
REQ-017 SHALL keep registers scroll_x (0..IMG_W-1), scroll_y (0..IMG_H-1), x (0..IMG_W-1), y (0..IMG_H-1), xw (x-wrapped flag) and yw (y-wrapped flag).
REQ-018 SHALL compute x_base = H_OFF+scroll_x and y_base = V_OFF+scroll_y, each reduced by one conditional subtract of IMG_W or IMG_H; no divide or % operator.
REQ-019 SHALL, on pix_en with h_cnt==0, load x <= x_base and clear xw.
REQ-020 SHALL, on pix_en with h_cnt!=0, step x <= x+1, except x==IMG_W-1 wraps to 0 and sets xw.
REQ-021 SHALL, on pix_en with h_cnt==0 and v_cnt==0, load y <= y_base and clear yw.
REQ-022 SHALL, on pix_en with h_cnt==0 and v_cnt!=0, step y <= y+1, except y==IMG_H-1 wraps to 0 and sets yw.
REQ-023 SHALL leave y unchanged on pix_en with h_cnt!=0.
REQ-024 SHALL, on pix_en, register pixel_addr <= y_next*IMG_W + x_next; latency is 1 pix_en-qualified cycle from the h_cnt/v_cnt sample.
REQ-025 SHALL compute the multiply at full width before truncation to ADDR_W.
REQ-026 SHALL hold pixel_addr, in_range and x/y unchanged while pix_en is low.
REQ-027 SHALL, with clip_mode=0, register in_range <= 1 on every pix_en.
REQ-028 SHALL, with clip_mode=1, register in_range <= !(xw_next|yw_next).
REQ-029 SHALL, with clip_mode=1 and in_range=0, still output the wrapped pixel_addr.
REQ-030 SHALL, on frame_start with scroll_en[0], advance scroll_x by STEP modulo IMG_W.
REQ-031 SHALL, on frame_start with scroll_en[1], advance scroll_y by STEP modulo IMG_H.
REQ-032 SHALL leave a scroll axis unchanged when its scroll_en bit is 0.
REQ-033 SHALL, when frame_start coincides with pix_en at h_cnt==0,v_cnt==0, use the pre-update scroll values in the load; the new scroll applies from the next frame.
REQ-034 SHALL treat h_cnt/v_cnt beyond the visible area as normal counting; the state reloads at the next h_cnt==0.
REQ-035 SHALL evaluate clip_mode every cycle; a change takes effect on the next pix_en.

Reset
REQ-036 SHALL, while rst_n is low and regardless of clk, force scroll_x, scroll_y, x, y, xw, yw, pixel_addr and in_range to 0.
REQ-037 SHALL, after rst_n is released mid-frame, produce consistent addresses only from the next h_cnt==0 (x) and v_cnt==0 (y); prior outputs are unspecified but in range.

Verification
REQ-038 SHALL check defaults: pix_en at h=0,v=0 -> pixel_addr=5180, in_range=1; h=19 -> 5199.
REQ-039 SHALL check x wrap: h=20,v=0 gives 5000; with clip_mode=1 in_range=0; at h=0 of the next line (v=1) in_range=1 and addr=5380.
REQ-040 SHALL check y wrap: v=65,h=0 gives 180; with clip_mode=1 in_range=0 for the rest of the frame.
REQ-041 SHALL check horizontal scroll: scroll_en=01, one frame_start then h=0,v=0 -> 5184; five frame_starts total -> 5000.
REQ-042 SHALL check coincidence: frame_start with pix_en at h=0,v=0 -> that frame loads 5180, the next frame 5184.
REQ-043 SHALL check async reset: rst_n low between clk edges -> pixel_addr=0, in_range=0 immediately; scroll restarts from 0.
